// File: rtl/usb_link_if.sv
// Pad/core signal bundle for the USB link controller.
// Ports: pad rx levels, core tx request, wake request in; pad tx, core reset, status out.
interface usb_link_if;
    logic       rx_j;
    logic       rx_se0;
    logic       core_tx_se0;
    logic       core_tx_j;
    logic       core_tx_en;
    logic       wake_req;
    logic       tx_se0;
    logic       tx_j;
    logic       tx_en;
    logic       core_rst_n;
    logic       bus_reset;
    logic       suspended;
    logic       wake_ack;
    logic [2:0] state;

    modport slave (
        input  rx_j, rx_se0, core_tx_se0, core_tx_j, core_tx_en, wake_req,
        output tx_se0, tx_j, tx_en, core_rst_n, bus_reset, suspended,
        output wake_ack, state
    );

    modport master (
        output rx_j, rx_se0, core_tx_se0, core_tx_j, core_tx_en, wake_req,
        input  tx_se0, tx_j, tx_en, core_rst_n, bus_reset, suspended,
        input  wake_ack, state
    );
endinterface

// File: rtl/usb_link_ctrl.sv
// USB bus-state controller: detects bus reset, suspend, resume; owns the pad transmitter.
// Ports: clk48, rst_n (async, active-low), bus (usb_link_if.slave: pad rx/tx, core tx, status).
module usb_link_ctrl #(
    parameter int RESET_CYCLES        = 120,
    parameter int SUSPEND_CYCLES      = 144000,
    parameter int WAKE_HOLDOFF_CYCLES = 240000,
    parameter int RESUME_DRIVE_CYCLES = 96000
) (
    input  logic        clk48,
    input  logic        rst_n,
    usb_link_if.slave   bus
);
    localparam int SW = $clog2(RESET_CYCLES + 1);
    localparam int IW = $clog2(SUSPEND_CYCLES + 1);
    localparam int HW = $clog2(WAKE_HOLDOFF_CYCLES + 1);
    localparam int DW = $clog2(RESUME_DRIVE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_ACTIVE      = 3'd1,
        ST_SUSPEND     = 3'd2,
        ST_HOST_RESUME = 3'd3,
        ST_WAKE_DRIVE  = 3'd4
    } state_t;

    state_t        st;
    logic [1:0]    j_sync;
    logic [1:0]    se0_sync;
    logic [1:0]    vld;
    logic [SW-1:0] se0_cnt;
    logic [IW-1:0] idle_cnt;
    logic [HW-1:0] hold_cnt;
    logic [DW-1:0] drv_cnt;
    logic          core_rst_q;
    logic          bus_reset_q;
    logic          suspended_q;
    logic          wake_ack_q;

    logic line_se0;
    logic line_j;
    logic line_k;
    logic idle;
    logic se0_full;
    logic idle_last;
    logic hold_full;
    logic drv_last;

    // vld marks when the synchroniser holds real pad samples rather
    // than its reset placeholders, so RESET is not left on stale data.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            j_sync   <= 2'b11;
            se0_sync <= 2'b00;
            vld      <= 2'b00;
        end else begin
            j_sync   <= {j_sync[0], bus.rx_j};
            se0_sync <= {se0_sync[0], bus.rx_se0};
            vld      <= {vld[0], 1'b1};
        end
    end

    assign line_se0  = se0_sync[1];
    assign line_j    = j_sync[1] & ~line_se0;
    assign line_k    = ~j_sync[1] & ~line_se0;
    assign idle      = line_j & ~bus.core_tx_en;
    assign se0_full  = (se0_cnt == SW'(RESET_CYCLES));
    assign idle_last = idle && (idle_cnt == IW'(SUSPEND_CYCLES - 1));
    assign hold_full = (hold_cnt == HW'(WAKE_HOLDOFF_CYCLES));
    assign drv_last  = (drv_cnt == DW'(RESUME_DRIVE_CYCLES - 1));

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            se0_cnt  <= '0;
            idle_cnt <= '0;
            hold_cnt <= '0;
            drv_cnt  <= '0;
        end else begin
            if (st == ST_WAKE_DRIVE || !line_se0)
                se0_cnt <= '0;
            else if (!se0_full)
                se0_cnt <= se0_cnt + SW'(1);

            if (st != ST_ACTIVE || !idle)
                idle_cnt <= '0;
            else if (idle_cnt != IW'(SUSPEND_CYCLES))
                idle_cnt <= idle_cnt + IW'(1);

            if (st != ST_SUSPEND)
                hold_cnt <= '0;
            else if (!hold_full)
                hold_cnt <= hold_cnt + HW'(1);

            if (st != ST_WAKE_DRIVE)
                drv_cnt <= '0;
            else
                drv_cnt <= drv_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            st          <= ST_RESET;
            core_rst_q  <= 1'b0;
            bus_reset_q <= 1'b0;
            suspended_q <= 1'b0;
            wake_ack_q  <= 1'b0;
        end else begin
            bus_reset_q <= 1'b0;
            wake_ack_q  <= 1'b0;
            unique case (st)
                ST_RESET: begin
                    if (vld[1] && !line_se0) begin
                        st         <= ST_ACTIVE;
                        core_rst_q <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (se0_full) begin
                        st          <= ST_RESET;
                        core_rst_q  <= 1'b0;
                        bus_reset_q <= 1'b1;
                    end else if (idle_last) begin
                        st          <= ST_SUSPEND;
                        suspended_q <= 1'b1;
                    end
                end
                ST_SUSPEND: begin
                    if (se0_full) begin
                        st          <= ST_RESET;
                        core_rst_q  <= 1'b0;
                        bus_reset_q <= 1'b1;
                        suspended_q <= 1'b0;
                    end else if (line_k) begin
                        st          <= ST_HOST_RESUME;
                        suspended_q <= 1'b0;
                    end else if (bus.wake_req && hold_full) begin
                        st          <= ST_WAKE_DRIVE;
                        suspended_q <= 1'b0;
                        wake_ack_q  <= 1'b1;
                    end
                end
                ST_HOST_RESUME: begin
                    if (se0_full) begin
                        st          <= ST_RESET;
                        core_rst_q  <= 1'b0;
                        bus_reset_q <= 1'b1;
                    end else if (line_j) begin
                        st <= ST_ACTIVE;
                    end
                end
                ST_WAKE_DRIVE: begin
                    if (drv_last)
                        st <= ST_HOST_RESUME;
                end
                default: begin
                    st          <= ST_RESET;
                    core_rst_q  <= 1'b0;
                    suspended_q <= 1'b0;
                end
            endcase
        end
    end

    // Only ACTIVE lets the core reach the pads; WAKE_DRIVE forces K.
    assign bus.tx_en  = (st == ST_ACTIVE) ? bus.core_tx_en : (st == ST_WAKE_DRIVE);
    assign bus.tx_j   = (st == ST_ACTIVE) ? bus.core_tx_j : (st != ST_WAKE_DRIVE);
    assign bus.tx_se0 = (st == ST_ACTIVE) ? bus.core_tx_se0 : 1'b0;

    assign bus.core_rst_n = core_rst_q;
    assign bus.bus_reset  = bus_reset_q;
    assign bus.suspended  = suspended_q;
    assign bus.wake_ack   = wake_ack_q;
    assign bus.state      = st;
endmodule
